// File: rtl/ap_hs_frame_source.sv
// ap_hs producer: on ap_start emits one frame of cfg_len beats (cfg_base + k*cfg_step)
// over independent value/last ap_vld/ap_ack channels, with ap_start/ap_done/ap_idle/ap_ready control.
module ap_hs_frame_source #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [DATA_W-1:0] cfg_base,
    input  logic [DATA_W-1:0] cfg_step,
    output logic [DATA_W-1:0] value_V,
    output logic              value_V_ap_vld,
    input  logic              value_V_ap_ack,
    output logic              last_V,
    output logic              last_V_ap_vld,
    input  logic              last_V_ap_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  k_q;
    logic [DATA_W-1:0] step_q;
    logic [DATA_W-1:0] value_q;
    logic              last_q;
    logic              vvld_q;
    logic              lvld_q;
    logic              done_q;
    logic              idle_q;

    logic              v_hold;
    logic              l_hold;
    logic              advance;
    logic [LEN_W-1:0]  k_d;
    logic [DATA_W-1:0] value_d;
    logic              last_d;

    // A beat advances once neither channel still has an untransferred beat pending.
    always_comb begin
        v_hold  = vvld_q & ~value_V_ap_ack;
        l_hold  = lvld_q & ~last_V_ap_ack;
        advance = ~v_hold & ~l_hold;
        k_d     = k_q + LEN_W'(1);
        value_d = value_q + step_q;
        last_d  = (k_d == (len_q - LEN_W'(1)));
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            k_q     <= '0;
            step_q  <= '0;
            value_q <= '0;
            last_q  <= 1'b0;
            vvld_q  <= 1'b0;
            lvld_q  <= 1'b0;
            done_q  <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ap_start) begin
                        len_q   <= cfg_len;
                        step_q  <= cfg_step;
                        k_q     <= '0;
                        value_q <= cfg_base;
                        idle_q  <= 1'b0;
                        if (cfg_len != '0) begin
                            state_q <= SEND;
                            vvld_q  <= 1'b1;
                            lvld_q  <= 1'b1;
                            last_q  <= (cfg_len == LEN_W'(1));
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (advance) begin
                        if (last_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            vvld_q  <= 1'b0;
                            lvld_q  <= 1'b0;
                        end else begin
                            k_q     <= k_d;
                            value_q <= value_d;
                            last_q  <= last_d;
                            vvld_q  <= 1'b1;
                            lvld_q  <= 1'b1;
                        end
                    end else begin
                        if (vvld_q && value_V_ap_ack) vvld_q <= 1'b0;
                        if (lvld_q && last_V_ap_ack)  lvld_q <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    idle_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    idle_q  <= 1'b1;
                end
            endcase
        end
    end

    assign ap_done        = done_q;
    assign ap_ready       = done_q;
    assign ap_idle        = idle_q;
    assign value_V        = value_q;
    assign value_V_ap_vld = vvld_q;
    assign last_V         = last_q;
    assign last_V_ap_vld  = lvld_q;

endmodule

// File: tb/tb_ap_hs_frame_source.sv
// Bench for ap_hs_frame_source: queue-based beat model checked every cycle, plus directed
// literal expectations for each scenario.
module tb_ap_hs_frame_source;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        ap_start = 1'b0;
    logic        ap_done, ap_idle, ap_ready;
    logic [15:0] cfg_len = '0;
    logic [7:0]  cfg_base = '0;
    logic [7:0]  cfg_step = '0;
    logic [7:0]  value_V;
    logic        value_V_ap_vld;
    logic        value_V_ap_ack = 1'b0;
    logic        last_V;
    logic        last_V_ap_vld;
    logic        last_V_ap_ack = 1'b0;

    ap_hs_frame_source #(.DATA_W(8), .LEN_W(16)) dut (
        .ap_clk         (ap_clk),
        .ap_rst_n       (ap_rst_n),
        .ap_start       (ap_start),
        .ap_done        (ap_done),
        .ap_idle        (ap_idle),
        .ap_ready       (ap_ready),
        .cfg_len        (cfg_len),
        .cfg_base       (cfg_base),
        .cfg_step       (cfg_step),
        .value_V        (value_V),
        .value_V_ap_vld (value_V_ap_vld),
        .value_V_ap_ack (value_V_ap_ack),
        .last_V         (last_V),
        .last_V_ap_vld  (last_V_ap_vld),
        .last_V_ap_ack  (last_V_ap_ack)
    );

    always #5 ap_clk = ~ap_clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: a frame is the queue of beats still to be delivered; each beat leaves once
    // both channels have taken it.
    typedef struct {
        logic [7:0] v;
        logic       l;
    } beat_t;

    beat_t      mq[$];
    bit         vdone = 1'b0;
    bit         ldone = 1'b0;
    bit         exp_done = 1'b0;
    bit         exp_idle = 1'b1;
    logic [7:0] seen_v[$];
    logic       seen_l[$];

    always @(negedge ap_rst_n) begin
        mq.delete();
        vdone    = 1'b0;
        ldone    = 1'b0;
        exp_done = 1'b0;
        exp_idle = 1'b1;
    end

    always @(posedge ap_clk) begin : model
        beat_t b;
        if (ap_rst_n === 1'b1) begin
            if (value_V_ap_vld && value_V_ap_ack) seen_v.push_back(value_V);
            if (last_V_ap_vld && last_V_ap_ack)   seen_l.push_back(last_V);
            if (exp_done) begin
                exp_done = 1'b0;
                exp_idle = 1'b1;
            end else if (exp_idle) begin
                if (ap_start) begin
                    exp_idle = 1'b0;
                    if (cfg_len == 0) exp_done = 1'b1;
                    else begin
                        for (int i = 0; i < int'(cfg_len); i++) begin
                            b.v = 8'((int'(cfg_base) + i * int'(cfg_step)) & 255);
                            b.l = (i == int'(cfg_len) - 1);
                            mq.push_back(b);
                        end
                    end
                end
            end else if (mq.size() != 0) begin
                if (value_V_ap_ack) vdone = 1'b1;
                if (last_V_ap_ack)  ldone = 1'b1;
                if (vdone && ldone) begin
                    void'(mq.pop_front());
                    vdone = 1'b0;
                    ldone = 1'b0;
                    if (mq.size() == 0) exp_done = 1'b1;
                end
            end
        end
    end

    always @(negedge ap_clk) begin : compare
        logic ev, el;
        if (chk_en) begin
            ev = (mq.size() != 0) && !vdone;
            el = (mq.size() != 0) && !ldone;
            chk("ap_idle", ap_idle, exp_idle);
            chk("ap_done", ap_done, exp_done);
            chk("ap_ready", ap_ready, exp_done);
            chk("value_vld", value_V_ap_vld, ev);
            chk("last_vld", last_V_ap_vld, el);
            if (ev) chk("value_V", value_V, mq[0].v);
            if (el) chk("last_V", last_V, mq[0].l);
        end
    end

    task automatic tick();
        @(negedge ap_clk);
    endtask

    task automatic start_frame(input int len, input int base, input int step);
        cfg_len  = 16'(len);
        cfg_base = 8'(base);
        cfg_step = 8'(step);
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
    endtask

    task automatic clear_seen();
        seen_v.delete();
        seen_l.delete();
    endtask

    task automatic chk_seen(input string tag, input int n, input int ev[6], input int el[6]);
        chk($sformatf("%s_nval", tag), seen_v.size(), n);
        chk($sformatf("%s_nlast", tag), seen_l.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < seen_v.size()) chk($sformatf("%s_val%0d", tag, i), seen_v[i], ev[i]);
            if (i < seen_l.size()) chk($sformatf("%s_last%0d", tag, i), seen_l[i], el[i]);
        end
    endtask

    initial begin
        ap_rst_n = 1'b1;
        #1 ap_rst_n = 1'b0;
        tick();
        tick();
        chk("rst_idle", ap_idle, 1);
        chk("rst_done", ap_done, 0);
        chk("rst_ready", ap_ready, 0);
        chk("rst_vvld", value_V_ap_vld, 0);
        chk("rst_lvld", last_V_ap_vld, 0);
        chk("rst_value", value_V, 0);
        chk("rst_last", last_V, 0);
        ap_rst_n = 1'b1;
        chk_en   = 1'b1;
        tick();

        // Basic frame
        clear_seen();
        value_V_ap_ack = 1'b1;
        last_V_ap_ack  = 1'b1;
        start_frame(4, 10, 1);
        chk("t1_first", value_V, 10);
        chk("t1_first_vld", value_V_ap_vld, 1);
        repeat (3) tick();
        chk("t1_lastval", value_V, 13);
        chk("t1_lastflag", last_V, 1);
        tick();
        chk("t1_done", ap_done, 1);
        chk("t1_ready", ap_ready, 1);
        tick();
        chk("t1_idle", ap_idle, 1);
        chk_seen("t1", 4, '{10, 11, 12, 13, 0, 0}, '{0, 0, 0, 1, 0, 0});

        // Split acks
        clear_seen();
        value_V_ap_ack = 1'b0;
        last_V_ap_ack  = 1'b0;
        start_frame(2, 0, 5);
        value_V_ap_ack = 1'b1;
        tick();
        chk("t2_vvld_c2", value_V_ap_vld, 0);
        chk("t2_lvld_c2", last_V_ap_vld, 1);
        chk("t2_val_c2", value_V, 0);
        value_V_ap_ack = 1'b0;
        tick();
        chk("t2_vvld_c3", value_V_ap_vld, 0);
        last_V_ap_ack = 1'b1;
        tick();
        last_V_ap_ack = 1'b0;
        chk("t2_beat1", value_V, 5);
        chk("t2_beat1_last", last_V, 1);
        value_V_ap_ack = 1'b1;
        last_V_ap_ack  = 1'b1;
        tick();
        chk("t2_done", ap_done, 1);
        tick();
        chk_seen("t2", 2, '{0, 5, 0, 0, 0, 0}, '{0, 1, 0, 0, 0, 0});

        // Backpressure during beat 1
        clear_seen();
        start_frame(3, 20, 7);
        tick();
        value_V_ap_ack = 1'b0;
        last_V_ap_ack  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t3_hold_val%0d", i), value_V, 27);
            chk($sformatf("t3_hold_last%0d", i), last_V, 0);
            chk($sformatf("t3_hold_vld%0d", i), {value_V_ap_vld, last_V_ap_vld}, 2'b11);
        end
        value_V_ap_ack = 1'b1;
        last_V_ap_ack  = 1'b1;
        tick();
        chk("t3_beat2", value_V, 34);
        tick();
        chk("t3_done", ap_done, 1);
        tick();
        chk_seen("t3", 3, '{20, 27, 34, 0, 0, 0}, '{0, 0, 1, 0, 0, 0});

        // Zero length, then wrap
        clear_seen();
        start_frame(0, 55, 9);
        chk("t4_zero_done", ap_done, 1);
        chk("t4_zero_vld", value_V_ap_vld, 0);
        tick();
        chk("t4_zero_idle", ap_idle, 1);
        chk("t4_zero_nbeats", seen_v.size(), 0);
        start_frame(3, 250, 3);
        repeat (3) tick();
        chk("t4_wrap_done", ap_done, 1);
        tick();
        chk_seen("t4", 3, '{250, 253, 0, 0, 0, 0}, '{0, 0, 1, 0, 0, 0});

        // Reset mid-frame
        clear_seen();
        start_frame(6, 40, 2);
        tick();
        tick();
        chk("t5_beat2", value_V, 44);
        #2 ap_rst_n = 1'b0;
        #1;
        chk("t5_rst_vvld", value_V_ap_vld, 0);
        chk("t5_rst_lvld", last_V_ap_vld, 0);
        chk("t5_rst_idle", ap_idle, 1);
        chk("t5_rst_done", ap_done, 0);
        tick();
        tick();
        ap_rst_n = 1'b1;
        chk("t5_pre_n", seen_v.size(), 2);
        tick();
        clear_seen();
        start_frame(6, 40, 2);
        chk("t5_restart", value_V, 40);
        repeat (5) tick();
        chk("t5_final", value_V, 50);
        tick();
        chk("t5_done", ap_done, 1);
        tick();
        chk_seen("t5", 6, '{40, 42, 44, 46, 48, 50}, '{0, 0, 0, 0, 0, 1});

        // Start and cfg changes ignored while busy
        clear_seen();
        cfg_len  = 16'd3;
        cfg_base = 8'd100;
        cfg_step = 8'd10;
        ap_start = 1'b1;
        tick();
        cfg_base = 8'd200;
        tick();
        ap_start = 1'b0;
        cfg_base = 8'd55;
        chk("t6_beat1", value_V, 110);
        tick();
        chk("t6_beat2", value_V, 120);
        tick();
        chk("t6_done", ap_done, 1);
        repeat (5) tick();
        chk("t6_still_idle", ap_idle, 1);
        chk("t6_no_vld", value_V_ap_vld, 0);
        chk_seen("t6", 3, '{100, 110, 120, 0, 0, 0}, '{0, 0, 1, 0, 0, 0});

        chk("model_drained", mq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
